// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl: sequences full-row removal after a piece locks.
// Scans the board's per-row full flags, issues one shift strobe per cleared
// row (highest full row first), waits for the board store to settle, rescans
// until no full row remains, then reports the number of lines cleared.
// Optional feature macro: LINE_CLEAR_SCORE_EN adds a saturating score
// accumulator; without it score_o is tied to zero.
module line_clear_ctrl #(
  parameter int ROWS       = 23,
  parameter int SETTLE     = 2,
  parameter int MAX_CLEARS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [ROWS-1:0] rowfull_i,
  output logic            busy_o,
  output logic            shift_en_o,
  output logic [ROWS-1:0] shift_mask_o,
  output logic            done_o,
  output logic [2:0]      lines_cleared_o,
  output logic            err_o,
  output logic [15:0]     score_o
);

  localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_SHIFT,
    S_SETTLE,
    S_DONE
  } state_e;

  state_e          state_q;
  logic [2:0]      count_q;
  logic [SCW-1:0]  settle_q;
  logic            busy_q;
  logic            shift_en_q;
  logic            done_q;
  logic            err_q;
  logic [2:0]      lines_q;
  logic [ROWS-1:0] mask_q;
  logic [ROWS-1:0] mask_d;
  logic            acc;

  // Mask covers rows 0..k where k is the highest full row (suffix OR from the top)
  always_comb begin
    mask_d = '0;
    acc    = 1'b0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      acc       = acc | rowfull_i[i];
      mask_d[i] = acc;
    end
  end

  // Control FSM with registered outputs; reset aborts any sequence in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      settle_q   <= '0;
      busy_q     <= 1'b0;
      shift_en_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      lines_q    <= '0;
      mask_q     <= '0;
    end else begin
      shift_en_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_SCAN;
            count_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_SCAN: begin
          if (rowfull_i == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            lines_q <= count_q;
          end else if (count_q == 3'(MAX_CLEARS)) begin
            // Too many full rows for one lock: flag it but still finish cleanly
            state_q <= S_DONE;
            done_q  <= 1'b1;
            lines_q <= count_q;
            err_q   <= 1'b1;
          end else begin
            state_q    <= S_SHIFT;
            mask_q     <= mask_d;
            shift_en_q <= 1'b1;
          end
        end
        S_SHIFT: begin
          count_q  <= count_q + 3'd1;
          settle_q <= SCW'(SETTLE - 1);
          state_q  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_q == '0) begin
            state_q <= S_SCAN;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o          = busy_q;
  assign shift_en_o      = shift_en_q;
  assign shift_mask_o    = mask_q;
  assign done_o          = done_q;
  assign lines_cleared_o = lines_q;
  assign err_o           = err_q;

`ifdef LINE_CLEAR_SCORE_EN
  logic [15:0] score_q;

  // Points awarded for a sequence clearing n lines
  function automatic logic [15:0] line_points(input logic [2:0] n);
    case (n)
      3'd1:    line_points = 16'd40;
      3'd2:    line_points = 16'd100;
      3'd3:    line_points = 16'd300;
      3'd4:    line_points = 16'd1200;
      default: line_points = 16'd0;
    endcase
  endfunction

  // Unsigned add clamped at full scale
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    sat_add = sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // Accumulate while in DONE, where lines_q already holds this sequence's count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q <= '0;
    end else if (state_q == S_DONE) begin
      score_q <= sat_add(score_q, line_points(lines_q));
    end
  end

  assign score_o = score_q;
`else
  assign score_o = 16'd0;
`endif

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Directed bench for line_clear_ctrl: reacts to shift strobes like the board
// store would and checks timing, masks, counts, error flag, reset and score.
module tb_line_clear_ctrl;

  localparam int ROWS   = 23;
  localparam int SETTLE = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start_i = 1'b0;
  logic [ROWS-1:0] rowfull_i = '0;
  logic            busy_o;
  logic            shift_en_o;
  logic [ROWS-1:0] shift_mask_o;
  logic            done_o;
  logic [2:0]      lines_cleared_o;
  logic            err_o;
  logic [15:0]     score_o;

  line_clear_ctrl #(.ROWS(ROWS), .SETTLE(SETTLE), .MAX_CLEARS(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start_i),
    .rowfull_i       (rowfull_i),
    .busy_o          (busy_o),
    .shift_en_o      (shift_en_o),
    .shift_mask_o    (shift_mask_o),
    .done_o          (done_o),
    .lines_cleared_o (lines_cleared_o),
    .err_o           (err_o),
    .score_o         (score_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int failed = 0;

  int            n_shift;
  int            first_n;
  int            done_n;
  int            last_n;
  int            gap_bad;
  logic          busy1;
  logic [ROWS-1:0] first_mask;
  int            exp_score = 0;
  logic          any_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int pts(input int n);
    case (n)
      1:       pts = 40;
      2:       pts = 100;
      3:       pts = 300;
      4:       pts = 1200;
      default: pts = 0;
    endcase
  endfunction

  task automatic add_score(input int n);
`ifdef LINE_CLEAR_SCORE_EN
    exp_score = exp_score + pts(n);
    if (exp_score > 65535) exp_score = 65535;
`else
    if (n < 0) exp_score = pts(n);
`endif
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Board response: every masked row i>0 takes row i-1, masked row 0 empties
  task automatic apply_shift(input logic [ROWS-1:0] m);
    for (int i = ROWS - 1; i >= 1; i--)
      if (m[i]) rowfull_i[i] = rowfull_i[i-1];
    if (m[0]) rowfull_i[0] = 1'b0;
  endtask

  // Called #1 after an edge: pulses start, follows the sequence up to done.
  // again_at re-pulses start at that cycle offset to probe no-queueing.
  task automatic run_seq(input int again_at);
    n_shift = 0; first_n = -1; done_n = -1; last_n = 0; gap_bad = 0;
    busy1 = 1'b0; first_mask = '0;
    start_i = 1'b1;
    for (int n = 1; n <= 120 && done_n < 0; n++) begin
      next_cycle();
      start_i = (n == again_at);
      if (n == 1) busy1 = busy_o;
      if (shift_en_o) begin
        if (n_shift == 0) begin
          first_n    = n;
          first_mask = shift_mask_o;
        end else if (n - last_n != 2 + SETTLE) begin
          gap_bad++;
        end
        last_n = n;
        n_shift++;
        apply_shift(shift_mask_o);
      end
      if (done_o) done_n = n;
    end
    start_i = 1'b0;
  endtask

  initial begin
    // Reset state
    next_cycle();
    next_cycle();
    check("rst_busy", busy_o, 0);
    check("rst_shift_en", shift_en_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_mask", shift_mask_o, 0);
    check("rst_lines", lines_cleared_o, 0);
    check("rst_score", score_o, 0);
    rst_n = 1'b1;
    next_cycle();

    // No full rows: done two cycles after start, nothing shifted
    rowfull_i = '0;
    run_seq(0);
    check("nc_busy_after_start", busy1, 1);
    check("nc_done_latency", done_n, 2);
    check("nc_shifts", n_shift, 0);
    check("nc_lines", lines_cleared_o, 0);
    next_cycle();
    check("nc_done_pulse_width", done_o, 0);
    check("nc_busy_idle", busy_o, 0);
    check("nc_score", score_o, exp_score);

    // Top row alone: all-ones mask, one clear
    rowfull_i = 23'h400000;
    run_seq(0);
    add_score(1);
    check("r22_first_shift", first_n, 2);
    check("r22_mask", first_mask, 23'h7FFFFF);
    check("r22_shifts", n_shift, 1);
    check("r22_done_at", done_n, 6);
    check("r22_lines", lines_cleared_o, 1);
    next_cycle();
    check("r22_score", score_o, exp_score);

    // Rows 10..13 full: four clears spaced 2+SETTLE
    rowfull_i = 23'h003C00;
    run_seq(0);
    add_score(4);
    check("q_first_mask", first_mask, 23'h003FFF);
    check("q_shifts", n_shift, 4);
    check("q_spacing", gap_bad, 0);
    check("q_done_at", done_n, 18);
    check("q_lines", lines_cleared_o, 4);
    check("q_err", err_o, 0);
    check("q_board_empty", rowfull_i, 0);
    next_cycle();
    check("q_score", score_o, exp_score);

    // Five full rows: four clears, then error flag, still completes
    rowfull_i = 23'h00001F;
    run_seq(0);
    add_score(4);
    check("e_first_mask", first_mask, 23'h00001F);
    check("e_shifts", n_shift, 4);
    check("e_done_at", done_n, 18);
    check("e_lines", lines_cleared_o, 4);
    check("e_err", err_o, 1);
    next_cycle();
    check("e_err_sticky", err_o, 1);
    check("e_score", score_o, exp_score);

    // Asynchronous reset during SETTLE
    rowfull_i = 23'h003C00;
    start_i = 1'b1;
    next_cycle();
    start_i = 1'b0;
    next_cycle();
    check("ar_shift_seen", shift_en_o, 1);
    apply_shift(shift_mask_o);
    next_cycle();
    check("ar_busy_in_settle", busy_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy", busy_o, 0);
    check("ar_shift_en", shift_en_o, 0);
    check("ar_done", done_o, 0);
    check("ar_err", err_o, 0);
    check("ar_mask", shift_mask_o, 0);
    check("ar_lines", lines_cleared_o, 0);
    check("ar_score", score_o, 0);
    exp_score = 0;
    next_cycle();
    next_cycle();
    check("ar_hold_shift_en", shift_en_o, 0);
    rst_n = 1'b1;
    next_cycle();

    // Clean sequence after reset, with a start pulse while busy
    rowfull_i = 23'h000020;
    run_seq(3);
    add_score(1);
    check("cl_shifts", n_shift, 1);
    check("cl_mask", first_mask, 23'h00003F);
    check("cl_done_at", done_n, 6);
    check("cl_lines", lines_cleared_o, 1);
    check("cl_err", err_o, 0);
    any_busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      any_busy = any_busy | busy_o | shift_en_o;
    end
    check("cl_start_not_queued", any_busy, 0);
    check("cl_score", score_o, exp_score);

    // Sixty four-line clears: score saturates
    for (int r = 0; r < 60; r++) begin
      rowfull_i = 23'h003C00;
      run_seq(0);
      add_score(4);
      next_cycle();
      if (r == 9) check("sat_score_mid", score_o, exp_score);
    end
    check("sat_lines", lines_cleared_o, 4);
    check("sat_score", score_o, exp_score);
    check("sat_err", err_o, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
